// File: rtl/hood_power_sequencer.sv
// Range hood power and maintenance sequencer.
// Owns the on/off state handed to exhaust_function, idle auto-shutdown,
// the timed self-clean cycle and the fan run-time maintenance reminder.
module hood_power_sequencer #(
  parameter int unsigned CLK_PER_SEC      = 100000000,
  parameter int unsigned LONG_PRESS_SEC   = 3,
  parameter int unsigned IDLE_TIMEOUT_SEC = 60,
  parameter int unsigned CLEAN_SEC        = 180,
  parameter int unsigned REMIND_SEC       = 36000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_key,
  input  logic        clean_key,
  input  logic        exhaust_busy,
  output logic        is_on,
  output logic        exhaust_enable,
  output logic        clean_active,
  output logic [7:0]  clean_countdown,
  output logic [15:0] runtime_sec,
  output logic        maintenance_reminder,
  output logic [2:0]  state
);

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned HW = (LONG_PRESS_SEC > 0) ? $clog2(LONG_PRESS_SEC + 1) : 1;
  localparam int unsigned IW = (IDLE_TIMEOUT_SEC > 0) ? $clog2(IDLE_TIMEOUT_SEC + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_PRESS_SEC);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT_SEC);
  localparam logic [7:0]    CLEAN_LOAD = 8'(CLEAN_SEC);
  localparam logic [15:0]   REMIND_LVL = 16'(REMIND_SEC);

  typedef enum logic [2:0] {
    ST_OFF     = 3'b000,
    ST_STANDBY = 3'b001,
    ST_WORKING = 3'b010,
    ST_CLEAN   = 3'b011
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          power_prev_q, power_prev_d;
  logic          clean_prev_q, clean_prev_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    countdown_q, countdown_d;
  logic [15:0]   runtime_q, runtime_d;
  logic          is_on_q, is_on_d;
  logic          exhaust_enable_q, exhaust_enable_d;
  logic          clean_active_q, clean_active_d;
  logic [2:0]    state_out_q, state_out_d;

  logic tick;
  logic power_rise;
  logic clean_rise;
  logic long_press;

  // State, datapath and registered-output flops; everything clears on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_OFF;
      presc_q          <= '0;
      power_prev_q     <= 1'b0;
      clean_prev_q     <= 1'b0;
      hold_q           <= '0;
      idle_q           <= '0;
      countdown_q      <= '0;
      runtime_q        <= '0;
      is_on_q          <= 1'b0;
      exhaust_enable_q <= 1'b0;
      clean_active_q   <= 1'b0;
      state_out_q      <= '0;
    end else begin
      state_q          <= state_d;
      presc_q          <= presc_d;
      power_prev_q     <= power_prev_d;
      clean_prev_q     <= clean_prev_d;
      hold_q           <= hold_d;
      idle_q           <= idle_d;
      countdown_q      <= countdown_d;
      runtime_q        <= runtime_d;
      is_on_q          <= is_on_d;
      exhaust_enable_q <= exhaust_enable_d;
      clean_active_q   <= clean_active_d;
      state_out_q      <= state_out_d;
    end
  end

  // Free-running 1 s prescaler and key edge detection.
  always_comb begin
    tick         = (presc_q == PRESC_LAST);
    presc_d      = tick ? '0 : presc_q + PW'(1);
    power_prev_d = power_key;
    clean_prev_d = clean_key;
    power_rise   = power_key & ~power_prev_q;
    clean_rise   = clean_key & ~clean_prev_q;
  end

  // Next state plus hold/idle/countdown/run-time updates; long press wins over all.
  always_comb begin
    state_d     = state_q;
    idle_d      = '0;
    countdown_d = countdown_q;
    runtime_d   = runtime_q;

    if (!power_key) begin
      hold_d = '0;
    end else if (tick && (hold_q < HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = hold_q;
    end

    long_press = (state_q != ST_OFF) && (hold_q == HOLD_MAX);

    if (long_press) begin
      state_d     = ST_OFF;
      countdown_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          countdown_d = '0;
          if (power_rise) begin
            state_d = ST_STANDBY;
            hold_d  = '0;
          end
        end
        ST_STANDBY: begin
          if (power_rise || clean_rise || exhaust_busy) begin
            idle_d = '0;
          end else if (tick && (idle_q < IDLE_MAX)) begin
            idle_d = idle_q + IW'(1);
          end else begin
            idle_d = idle_q;
          end
          if (exhaust_busy) begin
            state_d = ST_WORKING;
          end else if (clean_rise) begin
            state_d     = ST_CLEAN;
            countdown_d = CLEAN_LOAD;
          end else if (idle_q == IDLE_MAX) begin
            state_d = ST_OFF;
          end
        end
        ST_WORKING: begin
          if (tick && (runtime_q != 16'hFFFF)) begin
            runtime_d = runtime_q + 16'd1;
          end
          if (!exhaust_busy) begin
            state_d = ST_STANDBY;
          end
        end
        ST_CLEAN: begin
          // An abort coinciding with the final tick keeps the run-time.
          if (clean_rise) begin
            state_d     = ST_STANDBY;
            countdown_d = '0;
          end else if (tick) begin
            if (countdown_q == 8'd1) begin
              state_d     = ST_STANDBY;
              countdown_d = '0;
              runtime_d   = '0;
            end else begin
              countdown_d = countdown_q - 8'd1;
            end
          end
        end
        default: begin
          state_d     = ST_OFF;
          countdown_d = '0;
        end
      endcase
    end
  end

  // Output decode from the current state, registered one clock later.
  always_comb begin
    is_on_d          = 1'b0;
    exhaust_enable_d = 1'b0;
    clean_active_d   = 1'b0;
    state_out_d      = state_q;
    case (state_q)
      ST_STANDBY: begin
        is_on_d          = 1'b1;
        exhaust_enable_d = 1'b1;
      end
      ST_WORKING: begin
        is_on_d          = 1'b1;
        exhaust_enable_d = 1'b1;
      end
      ST_CLEAN: begin
        is_on_d        = 1'b1;
        clean_active_d = 1'b1;
      end
      default: begin
        is_on_d = 1'b0;
      end
    endcase
  end

  assign is_on                = is_on_q;
  assign exhaust_enable       = exhaust_enable_q;
  assign clean_active         = clean_active_q;
  assign clean_countdown      = countdown_q;
  assign runtime_sec          = runtime_q;
  assign maintenance_reminder = (runtime_q >= REMIND_LVL);
  assign state                = state_out_q;

endmodule
